// File: rtl/deser_arbiter_pkg.sv
// deser_arbiter_pkg: shared state encoding and id-width helper for the deserializer arbiter
package deser_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
  function automatic int src_id_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/deser_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at/after the pointer
module rr_arbiter
  import deser_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = src_id_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  // walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = N'(1) << ((int'(ptr_i) + i) % N);
        idx_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/deser_arbiter.sv
// deser_arbiter: shares one external MSB-first deserializer among SRC_CNT serial sources,
// one word per grant, tagging each completed word with its source id.
module deser_arbiter
  import deser_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int SRC_CNT = 4,
  localparam int IW = src_id_w(SRC_CNT),
  localparam int CW = $clog2(DATA_BUS_WIDTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      srst_ni,
  input  logic [SRC_CNT-1:0]        req_i,
  input  logic [SRC_CNT-1:0]        data_i,
  input  logic [SRC_CNT-1:0]        data_val_i,
  output logic [SRC_CNT-1:0]        gnt_o,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      deser_srst_o,
  input  logic [DATA_BUS_WIDTH-1:0] deser_data_i,
  input  logic                      deser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] data_o,
  output logic [IW-1:0]             src_id_o,
  output logic                      data_val_o,
  output logic                      abort_o
);
  state_t state_q, state_d;
  logic [SRC_CNT-1:0] gnt_q, gnt_d, arb_gnt;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, tag_q, tag_d, src_id_q, src_id_d, arb_idx, nxt_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic tag_vld_q, tag_vld_d, data_val_q, data_val_d, abort_q, abort_d;
  logic bit_val, last;

  rr_arbiter #(.N(SRC_CNT)) u_rr (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );

  assign bit_val = (state_q == BUSY) & data_val_i[idx_q];
  assign last = bit_val & (cnt_q == CW'(DATA_BUS_WIDTH - 1));
  assign nxt_ptr = (idx_q == IW'(SRC_CNT - 1)) ? '0 : idx_q + 1'b1;
  // a req drop on the last bit still lets that bit through
  assign ser_data_o = data_i[idx_q];
  assign ser_data_val_o = srst_ni & bit_val & (req_i[idx_q] | last);
  assign deser_srst_o = ~srst_ni | (state_q == FLUSH);
  assign gnt_o = gnt_q;
  assign data_o = data_q;
  assign src_id_o = src_id_q;
  assign data_val_o = data_val_q;
  assign abort_o = abort_q;

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    tag_vld_d = tag_vld_q;
    data_d = data_q;
    src_id_d = src_id_q;
    data_val_d = 1'b0;
    abort_d = 1'b0;
    if (deser_data_val_i && tag_vld_q) begin
      data_d = deser_data_i;
      src_id_d = tag_q;
      data_val_d = 1'b1;
      tag_vld_d = 1'b0;
    end
    case (state_q)
      IDLE: if (|req_i) begin
        state_d = BUSY;
        gnt_d = arb_gnt;
        idx_d = arb_idx;
        cnt_d = '0;
      end
      BUSY: if (last) begin
        state_d = IDLE;
        gnt_d = '0;
        ptr_d = nxt_ptr;
        tag_d = idx_q;
        tag_vld_d = 1'b1;
      end else if (!req_i[idx_q]) begin
        state_d = FLUSH;
        gnt_d = '0;
        ptr_d = nxt_ptr;
        abort_d = 1'b1;
      end else if (bit_val) begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      tag_q <= '0;
      tag_vld_q <= 1'b0;
      data_q <= '0;
      src_id_q <= '0;
      data_val_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      tag_vld_q <= tag_vld_d;
      data_q <= data_d;
      src_id_q <= src_id_d;
      data_val_q <= data_val_d;
      abort_q <= abort_d;
    end
  end
endmodule
